// File: rtl/branch_address_unit_if.sv
// Decode-to-branch-unit bundle: instruction operands in, registered target/flags/statistics out.
interface branch_address_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             stall;
  logic             flush;
  logic [XLEN-1:0]  imm;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [2:0]       instr_type;
  logic             is_branch;
  logic [2:0]       funct3;

  logic             out_valid;
  logic [XLEN-1:0]  address_target;
  logic [1:0]       flag_branch;
  logic             redirect;
  logic             misaligned;
  logic             illegal_branch;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;

  modport master (
    output in_valid, stall, flush, imm, pc, rs1, rs2, instr_type, is_branch, funct3,
    input  out_valid, address_target, flag_branch, redirect, misaligned, illegal_branch,
           branch_cnt, taken_cnt
  );

  modport slave (
    input  in_valid, stall, flush, imm, pc, rs1, rs2, instr_type, is_branch, funct3,
    output out_valid, address_target, flag_branch, redirect, misaligned, illegal_branch,
           branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_address_unit.sv
// Registered jump/branch/load/store address unit with branch resolution,
// alignment trap detection, stall/flush control and saturating branch statistics.
module branch_address_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IALIGN = 32,
  parameter int unsigned CNT_W  = 16
) (
  input logic                  clk,
  input logic                  rst,
  branch_address_unit_if.slave bus
);

  localparam logic [2:0] T_I = 3'd1;
  localparam logic [2:0] T_S = 3'd2;
  localparam logic [2:0] T_B = 3'd3;
  localparam logic [2:0] T_J = 3'd5;
  localparam bit         ALIGN32 = (IALIGN == 32);

  logic [XLEN-1:0]  w_sum_pc;
  logic [XLEN-1:0]  w_sum_rs1;
  logic [XLEN-1:0]  w_target;
  logic [1:0]       w_flag;
  logic             w_take;
  logic             w_cond;
  logic             w_illegal;
  logic             w_mis;
  logic             w_redirect;
  logic             w_accept;
  logic             w_count_branch;

  logic             r_out_valid;
  logic [XLEN-1:0]  r_target;
  logic [1:0]       r_flag;
  logic             r_redirect;
  logic             r_misaligned;
  logic             r_illegal;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  // Branch condition evaluation
  always_comb begin
    w_cond = 1'b0;
    case (bus.funct3)
      3'b000:  w_cond = (bus.rs1 == bus.rs2);
      3'b001:  w_cond = (bus.rs1 != bus.rs2);
      3'b100:  w_cond = ($signed(bus.rs1) <  $signed(bus.rs2));
      3'b101:  w_cond = ($signed(bus.rs1) >= $signed(bus.rs2));
      3'b110:  w_cond = (bus.rs1 <  bus.rs2);
      3'b111:  w_cond = (bus.rs1 >= bus.rs2);
      default: w_cond = 1'b0;
    endcase
  end

  // Target selection per instruction class; R/U and reserved encodings yield zero
  always_comb begin
    w_sum_pc  = bus.pc + bus.imm;
    w_sum_rs1 = bus.rs1 + bus.imm;
    w_target  = '0;
    w_flag    = 2'b00;
    w_take    = 1'b0;
    w_illegal = 1'b0;
    case (bus.instr_type)
      T_J: begin
        w_target = w_sum_pc;
        w_flag   = 2'b01;
        w_take   = 1'b1;
      end
      T_I: begin
        if (bus.is_branch) begin
          w_target = w_sum_rs1 & ~XLEN'(1);
          w_flag   = 2'b10;
          w_take   = 1'b1;
        end else begin
          w_target = w_sum_rs1;
        end
      end
      T_S: w_target = w_sum_rs1;
      T_B: begin
        w_target  = w_sum_pc;
        w_flag    = 2'b11;
        w_illegal = (bus.funct3[2:1] == 2'b01);
        w_take    = w_cond & ~w_illegal;
      end
      default: ;
    endcase
  end

  // Only taken control flow is alignment checked; a misaligned target traps instead of redirecting
  assign w_mis          = w_take & (ALIGN32 ? (w_target[1:0] != 2'b00) : w_target[0]);
  assign w_redirect     = w_take & ~w_mis;
  assign w_accept       = bus.in_valid & ~bus.stall & ~bus.flush;
  assign w_count_branch = w_accept & (bus.instr_type == T_B) & ~w_illegal;

  // Output register: reset > flush > stall > capture
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_out_valid  <= 1'b0;
      r_target     <= '0;
      r_flag       <= 2'b00;
      r_redirect   <= 1'b0;
      r_misaligned <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (!bus.stall) begin
      r_out_valid  <= bus.in_valid;
      r_target     <= bus.in_valid ? w_target : '0;
      r_flag       <= bus.in_valid ? w_flag : 2'b00;
      r_redirect   <= bus.in_valid & w_redirect;
      r_misaligned <= bus.in_valid & w_mis;
      r_illegal    <= bus.in_valid & w_illegal;
    end
  end

  // Saturating statistics; flush leaves them intact
  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else begin
      if (w_count_branch && (r_branch_cnt != '1))
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (w_count_branch && w_take && (r_taken_cnt != '1))
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid      = r_out_valid;
  assign bus.address_target = r_target;
  assign bus.flag_branch    = r_flag;
  assign bus.redirect       = r_redirect;
  assign bus.misaligned     = r_misaligned;
  assign bus.illegal_branch = r_illegal;
  assign bus.branch_cnt     = r_branch_cnt;
  assign bus.taken_cnt      = r_taken_cnt;

endmodule

// File: tb/tb_branch_address_unit.sv
// Directed bench: dut_a (IALIGN=32, CNT_W=4) and dut_b (IALIGN=16, CNT_W=16) share identical stimulus.
module tb_branch_address_unit;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  branch_address_unit_if #(.XLEN(32), .CNT_W(4))  if_a ();
  branch_address_unit_if #(.XLEN(32), .CNT_W(16)) if_b ();

  branch_address_unit #(.XLEN(32), .IALIGN(32), .CNT_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  branch_address_unit #(.XLEN(32), .IALIGN(16), .CNT_W(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [2:0] ty, input logic isb, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] r1, input logic [31:0] r2);
    if_a.in_valid = v;  if_b.in_valid = v;
    if_a.instr_type = ty; if_b.instr_type = ty;
    if_a.is_branch = isb; if_b.is_branch = isb;
    if_a.funct3 = f3;   if_b.funct3 = f3;
    if_a.pc = pc;       if_b.pc = pc;
    if_a.imm = imm;     if_b.imm = imm;
    if_a.rs1 = r1;      if_b.rs1 = r1;
    if_a.rs2 = r2;      if_b.rs2 = r2;
  endtask

  task automatic set_ctl(input logic st, input logic fl);
    if_a.stall = st; if_b.stall = st;
    if_a.flush = fl; if_b.flush = fl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_ctl(1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 3'($urandom_range(0, 7)), 1'($urandom), 3'($urandom), $urandom, $urandom, $urandom, $urandom);
      cycle();
    end
    total++; if (if_a.out_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", if_a.out_valid); else passed++;
    total++; if (if_a.address_target !== 32'h0) $display("FAIL rst_target: got %h exp 0", if_a.address_target); else passed++;
    total++; if (if_a.flag_branch !== 2'b00 || if_a.redirect !== 1'b0 || if_a.misaligned !== 1'b0 || if_a.illegal_branch !== 1'b0)
      $display("FAIL rst_flags: got %b/%b/%b/%b exp 0", if_a.flag_branch, if_a.redirect, if_a.misaligned, if_a.illegal_branch); else passed++;
    total++; if (if_a.branch_cnt !== 4'd0 || if_a.taken_cnt !== 4'd0) $display("FAIL rst_cnt: got %0d/%0d exp 0/0", if_a.branch_cnt, if_a.taken_cnt); else passed++;
    rst = 1'b0;
    set_in(1'b0, 3'd3, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    cycle();
    total++; if (if_a.out_valid !== 1'b0) $display("FAIL idle_valid: got %b exp 0", if_a.out_valid); else passed++;
  endtask

  task automatic test_jumps();
    set_in(1'b1, 3'd5, 1'b0, 3'b000, 32'h100, 32'h20, 32'h0, 32'h0);
    cycle();
    total++; if (if_a.out_valid !== 1'b1 || if_a.address_target !== 32'h120) $display("FAIL jal_target: got %b %h exp 1 00000120", if_a.out_valid, if_a.address_target); else passed++;
    total++; if (if_a.flag_branch !== 2'b01 || if_a.redirect !== 1'b1 || if_a.misaligned !== 1'b0) $display("FAIL jal_flags: got %b/%b/%b exp 01/1/0", if_a.flag_branch, if_a.redirect, if_a.misaligned); else passed++;
    set_in(1'b1, 3'd1, 1'b1, 3'b000, 32'h0, 32'h0, 32'h203, 32'h0);
    cycle();
    total++; if (if_a.address_target !== 32'h202 || if_a.flag_branch !== 2'b10) $display("FAIL jalr_target: got %h/%b exp 00000202/10", if_a.address_target, if_a.flag_branch); else passed++;
    total++; if (if_a.misaligned !== 1'b1 || if_a.redirect !== 1'b0) $display("FAIL jalr_mis32: got %b/%b exp 1/0", if_a.misaligned, if_a.redirect); else passed++;
    total++; if (if_b.misaligned !== 1'b0 || if_b.redirect !== 1'b1) $display("FAIL jalr_ok16: got %b/%b exp 0/1", if_b.misaligned, if_b.redirect); else passed++;
  endtask

  task automatic test_branches();
    set_in(1'b1, 3'd3, 1'b0, 3'b100, 32'h40, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'h1);
    cycle();
    total++; if (if_a.redirect !== 1'b1 || if_a.address_target !== 32'h38 || if_a.flag_branch !== 2'b11) $display("FAIL blt: got %b %h %b exp 1 00000038 11", if_a.redirect, if_a.address_target, if_a.flag_branch); else passed++;
    set_in(1'b1, 3'd3, 1'b0, 3'b110, 32'h40, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'h1);
    cycle();
    total++; if (if_a.redirect !== 1'b0 || if_a.misaligned !== 1'b0) $display("FAIL bltu: got %b/%b exp 0/0", if_a.redirect, if_a.misaligned); else passed++;
    set_in(1'b1, 3'd3, 1'b0, 3'b111, 32'h40, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'h1);
    cycle();
    total++; if (if_a.redirect !== 1'b1) $display("FAIL bgeu: got %b exp 1", if_a.redirect); else passed++;
    set_in(1'b1, 3'd3, 1'b0, 3'b000, 32'h40, 32'hFFFF_FFF8, 32'h5, 32'h5);
    cycle();
    total++; if (if_a.redirect !== 1'b1 || if_a.address_target !== 32'h38) $display("FAIL beq: got %b %h exp 1 00000038", if_a.redirect, if_a.address_target); else passed++;
    set_in(1'b1, 3'd3, 1'b0, 3'b001, 32'h40, 32'hFFFF_FFF8, 32'h5, 32'h5);
    cycle();
    total++; if (if_a.redirect !== 1'b0) $display("FAIL bne_eq: got %b exp 0", if_a.redirect); else passed++;
    set_in(1'b1, 3'd3, 1'b0, 3'b010, 32'h40, 32'hFFFF_FFF8, 32'h5, 32'h5);
    cycle();
    total++; if (if_a.illegal_branch !== 1'b1 || if_a.redirect !== 1'b0) $display("FAIL illegal: got %b/%b exp 1/0", if_a.illegal_branch, if_a.redirect); else passed++;
    total++; if (if_a.branch_cnt !== 4'd5 || if_a.taken_cnt !== 4'd3) $display("FAIL br_cnt: got %0d/%0d exp 5/3", if_a.branch_cnt, if_a.taken_cnt); else passed++;
  endtask

  task automatic test_loadstore();
    set_in(1'b1, 3'd2, 1'b0, 3'b000, 32'h0, 32'hFFFF_FFFC, 32'h1000, 32'h0);
    cycle();
    total++; if (if_a.address_target !== 32'hFFC || if_a.flag_branch !== 2'b00 || if_a.redirect !== 1'b0) $display("FAIL store: got %h %b %b exp 00000ffc 00 0", if_a.address_target, if_a.flag_branch, if_a.redirect); else passed++;
    set_in(1'b1, 3'd1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h1001, 32'h0);
    cycle();
    total++; if (if_a.address_target !== 32'h1001 || if_a.misaligned !== 1'b0) $display("FAIL load_odd: got %h %b exp 00001001 0", if_a.address_target, if_a.misaligned); else passed++;
    set_in(1'b1, 3'd4, 1'b0, 3'b000, 32'h500, 32'h7000, 32'h1, 32'h0);
    cycle();
    total++; if (if_a.out_valid !== 1'b1 || if_a.address_target !== 32'h0) $display("FAIL utype: got %b %h exp 1 00000000", if_a.out_valid, if_a.address_target); else passed++;
  endtask

  task automatic test_stall_flush();
    set_in(1'b1, 3'd5, 1'b0, 3'b000, 32'h200, 32'h4, 32'h0, 32'h0);
    cycle();
    set_ctl(1'b1, 1'b0);
    set_in(1'b1, 3'd3, 1'b0, 3'b000, 32'h0, 32'h8, 32'h1, 32'h1);
    for (int k = 0; k < 3; k++) begin
      cycle();
      total++; if (if_a.out_valid !== 1'b1 || if_a.address_target !== 32'h204 || if_a.flag_branch !== 2'b01 || if_a.redirect !== 1'b1)
        $display("FAIL stall_hold%0d: got %b %h %b %b exp 1 00000204 01 1", k, if_a.out_valid, if_a.address_target, if_a.flag_branch, if_a.redirect); else passed++;
    end
    total++; if (if_a.branch_cnt !== 4'd5) $display("FAIL stall_cnt: got %0d exp 5", if_a.branch_cnt); else passed++;
    set_ctl(1'b1, 1'b1);
    cycle();
    total++; if (if_a.out_valid !== 1'b0 || if_a.address_target !== 32'h0 || if_a.flag_branch !== 2'b00 || if_a.redirect !== 1'b0)
      $display("FAIL flush: got %b %h %b %b exp 0 0 00 0", if_a.out_valid, if_a.address_target, if_a.flag_branch, if_a.redirect); else passed++;
    total++; if (if_a.branch_cnt !== 4'd5 || if_a.taken_cnt !== 4'd3) $display("FAIL flush_cnt: got %0d/%0d exp 5/3", if_a.branch_cnt, if_a.taken_cnt); else passed++;
    set_ctl(1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    set_in(1'b1, 3'd5, 1'b0, 3'b000, 32'h0, 32'h10, 32'h0, 32'h0);
    cycle();
    total++; if (if_a.address_target !== 32'h10 || if_a.redirect !== 1'b1) $display("FAIL b2b_0: got %h %b exp 00000010 1", if_a.address_target, if_a.redirect); else passed++;
    set_in(1'b1, 3'd2, 1'b0, 3'b000, 32'h0, 32'h8, 32'h20, 32'h0);
    cycle();
    total++; if (if_a.address_target !== 32'h28 || if_a.redirect !== 1'b0) $display("FAIL b2b_1: got %h %b exp 00000028 0", if_a.address_target, if_a.redirect); else passed++;
    set_in(1'b0, 3'd5, 1'b0, 3'b000, 32'h0, 32'h10, 32'h0, 32'h0);
    cycle();
    total++; if (if_a.out_valid !== 1'b0 || if_a.address_target !== 32'h0 || if_a.redirect !== 1'b0) $display("FAIL bubble: got %b %h %b exp 0 0 0", if_a.out_valid, if_a.address_target, if_a.redirect); else passed++;
  endtask

  task automatic test_saturation();
    set_in(1'b1, 3'd3, 1'b0, 3'b000, 32'h80, 32'h4, 32'h9, 32'h9);
    for (int n = 1; n <= 20; n++) begin
      cycle();
      if (n == 10) begin
        total++; if (if_a.branch_cnt !== 4'd15 || if_a.taken_cnt !== 4'd13) $display("FAIL sat_mid: got %0d/%0d exp 15/13", if_a.branch_cnt, if_a.taken_cnt); else passed++;
      end
    end
    total++; if (if_a.branch_cnt !== 4'd15 || if_a.taken_cnt !== 4'd15) $display("FAIL sat_end: got %0d/%0d exp 15/15", if_a.branch_cnt, if_a.taken_cnt); else passed++;
    total++; if (if_b.branch_cnt !== 16'd25 || if_b.taken_cnt !== 16'd23) $display("FAIL wide_cnt: got %0d/%0d exp 25/23", if_b.branch_cnt, if_b.taken_cnt); else passed++;
  endtask

  task automatic test_midstream_reset();
    rst = 1'b1;
    set_in(1'b1, 3'd5, 1'b0, 3'b000, 32'h300, 32'h4, 32'h0, 32'h0);
    cycle();
    total++; if (if_a.out_valid !== 1'b0 || if_a.address_target !== 32'h0 || if_a.branch_cnt !== 4'd0 || if_a.taken_cnt !== 4'd0)
      $display("FAIL mid_rst: got %b %h %0d %0d exp 0 0 0 0", if_a.out_valid, if_a.address_target, if_a.branch_cnt, if_a.taken_cnt); else passed++;
    rst = 1'b0;
    cycle();
    total++; if (if_a.out_valid !== 1'b1 || if_a.address_target !== 32'h304) $display("FAIL post_rst: got %b %h exp 1 00000304", if_a.out_valid, if_a.address_target); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    set_ctl(1'b0, 1'b0);
    set_in(1'b0, 3'd0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
    #2;
    test_reset();
    test_jumps();
    test_branches();
    test_loadstore();
    test_stall_flush();
    test_back_to_back();
    test_saturation();
    test_midstream_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/branch_address_unit.md
# branch_address_unit

Parametrised, registered successor to the single-cycle address builder in the RISC-V datapath. It computes jump, branch, load and store target addresses. It also evaluates the branch condition from rs1/rs2/funct3, flags misaligned control-flow targets and raises a single redirect request. All results are presented one clock after the decode stage, with stall/flush control and saturating branch statistics counters.

## Interface
- XLEN, 32, datapath and address width
- IALIGN, 32, instruction alignment in bits; legal values are 32 (target[1:0] must be 0) or 16 (target[0] must be 0)
- CNT_W, 16, width of the statistics counters
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode stage presents a valid instruction
- stall  in  1  hold the output register
- flush  in  1  kill the instruction being captured
- imm  in  XLEN  sign-extended immediate
- pc  in  XLEN  PC of the instruction
- rs1, rs2  in  XLEN  register operands
- instr_type  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are treated as R
- is_branch  in  1  for I type, marks JALR
- funct3  in  3  branch condition select
- out_valid  out  1  registered outputs hold a valid instruction
- address_target  out  XLEN  computed address
- flag_branch  out  2  00=none, 01=JAL, 10=JALR, 11=conditional branch
- redirect  out  1  fetch must jump to address_target
- misaligned  out  1  control-flow target violates IALIGN (trap request)
- illegal_branch  out  1  B type with funct3 010 or 011
- branch_cnt, taken_cnt  out  CNT_W  accepted B-type instructions / accepted taken branches

## Operation
- Combinational next values; all arithmetic is modulo 2^XLEN and carries are discarded:
  - J: target = pc+imm, flag 01, take=1.
  - I with is_branch=1: target = (rs1+imm) & ~1, flag 10, take=1.
  - I with is_branch=0: target = rs1+imm, flag 00, take=0.
  - S: target = rs1+imm, flag 00, take=0.
  - B: target = pc+imm, flag 11, take = condition result.
  - R, U, 6, 7: target = 0, flag 00, take=0.
- Branch conditions by funct3:
  - 000 BEQ (rs1==rs2); 001 BNE (rs1!=rs2).
  - 100 BLT, signed less-than; 101 BGE, signed greater-or-equal.
  - 110 BLTU, unsigned less-than; 111 BGEU, unsigned greater-or-equal.
  - 010 and 011: take=0, illegal_branch=1.
- Alignment check:
  - mis = take & (IALIGN==32 ? target[1:0]!=0 : target[0]).
  - redirect = take & ~mis. A misaligned target never redirects.
  - Non-control-flow addresses (loads/stores) are never checked.
- Accept condition: accept = in_valid & ~stall & ~flush.
- Output register update, in priority order:
  1. rst: all outputs 0.
  2. flush: out_valid=0 and all data/flag outputs 0, including while stall is high (flush beats stall).
  3. stall: all outputs hold.
  4. Otherwise: out_valid = in_valid. If in_valid=1, load the computed values. If in_valid=0, all data/flag outputs = 0.
- Counters:
  - Reset to 0. Flush does not clear them.
  - On accept of a B-type instruction with legal funct3, branch_cnt +1.
  - If that branch is also taken (misaligned included), taken_cnt +1.
  - Both counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Throughput is one instruction per cycle when stall=0.
- redirect, misaligned and illegal_branch are only asserted while out_valid=1.
- A reset asserted mid-stream clears the outputs and counters at the next edge; the input sampled at that edge is discarded.
- A stall held for k cycles keeps the outputs stable for k cycles. Inputs presented during the stall are not captured; the upstream stage must hold them.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold rst for 2 cycles with random inputs -> all outputs 0, both counters 0; after release with in_valid=0 -> out_valid stays 0.
- Jumps: J with pc=0x100, imm=0x20 -> next cycle target 0x120, flag 01, redirect 1. JALR with rs1=0x203, imm=0 -> target 0x202. With IALIGN=32 that gives misaligned=1, redirect=0; with IALIGN=16, redirect=1.
- Branch compares: rs1=0xFFFFFFFF, rs2=1 -> BLT taken, BLTU not taken, BGEU taken; BEQ with equal operands, pc=0x40, imm=-8 -> target 0x38, redirect 1; funct3=010 -> illegal_branch 1, no count.
- Loads/stores: S with rs1=0x1000, imm=-4 -> target 0xFFC, flag 00, redirect 0; U type -> target 0.
- Stall/flush: stall 3 cycles -> outputs frozen; stall and flush together -> out_valid 0 next cycle and counters unchanged.
- Counter saturation: CNT_W=4, 20 taken BEQs -> branch_cnt and taken_cnt stop at 15.
